spi_master_frame: RTL

Initiator end of the 32-bit tracking-motor SPI link: drives `cs`, `sclk` and `mosi` toward the FPGA slave, shifting out one motor-command frame while capturing one enemy-position frame on `miso`. It sits in the controller-side FPGA between the motor-command logic and the pins. Frames are SPI mode 0, MSB first, one frame per `cs` assertion, started by a single-cycle handshake.

---
 rtl/spi_frame_pkg.sv | 51 +++++
 rtl/spi_sclk_gen.sv | 48 ++++
 rtl/spi_master_frame.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_pkg.sv
// ============================================================================
// Module      : spi_frame_pkg
// Description : Frame layout, field types and FSM state encoding for the
//               32-bit tracking-motor SPI link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_frame_pkg;

    localparam int FRAME_W = 32;

    // Outbound motor-command frame: x[31:24] y[23:17] etc[16:0]
    localparam int MOSI_X_W     = 8;
    localparam int MOSI_Y_W     = 7;
    localparam int MOSI_ETC_W   = 17;
    localparam int MOSI_ETC_LSB = 0;
    localparam int MOSI_Y_LSB   = MOSI_ETC_LSB + MOSI_ETC_W;
    localparam int MOSI_X_LSB   = MOSI_Y_LSB + MOSI_Y_W;

    // Inbound enemy-position frame: x[31:22] y[21:13] etc[12:0]
    localparam int MISO_X_W     = 10;
    localparam int MISO_Y_W     = 9;
    localparam int MISO_ETC_W   = 13;
    localparam int MISO_ETC_LSB = 0;
    localparam int MISO_Y_LSB   = MISO_ETC_LSB + MISO_ETC_W;
    localparam int MISO_X_LSB   = MISO_Y_LSB + MISO_Y_W;

    typedef struct packed {
        logic [MOSI_X_W-1:0]   x;
        logic [MOSI_Y_W-1:0]   y;
        logic [MOSI_ETC_W-1:0] etc;
    } mosi_frame_t;

    typedef struct packed {
        logic [MISO_X_W-1:0]   x;
        logic [MISO_Y_W-1:0]   y;
        logic [MISO_ETC_W-1:0] etc;
    } miso_frame_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ============================================================================
// Module      : spi_sclk_gen
// Description : SPI serial-clock generator; toggles sclk every CLK_DIV cycles
//               while enabled and flags the cycle before each edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sclk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             sclk_q;
    logic             toggle;

    assign toggle = en && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (toggle) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Strobes lead the sclk edge by one cycle so the master acts on that edge.
    assign sclk = sclk_q;
    assign rise = toggle && !sclk_q;
    assign fall = toggle && sclk_q;

endmodule

`default_nettype wire

// File: rtl/spi_master_frame.sv
// ============================================================================
// Module      : spi_master_frame
// Description : SPI mode-0 master; sends one 32-bit motor-command frame and
//               captures one enemy-position frame per start handshake.
//               Optional auto-poll: define SPI_MASTER_AUTO_POLL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_frame
    import spi_frame_pkg::*;
#(
    parameter int CLK_DIV     = 8,
    parameter int POLL_PERIOD = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MOSI_X_W-1:0]   motor_xdata,
    input  logic [MOSI_Y_W-1:0]   motor_ydata,
    input  logic [MOSI_ETC_W-1:0] mosi_etc,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs,
    output logic                  busy,
    output logic                  done,
    output logic [MISO_X_W-1:0]   enemy_xdata,
    output logic [MISO_Y_W-1:0]   enemy_ydata,
    output logic [MISO_ETC_W-1:0] miso_etc
);

    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [5:0]       BIT_LAST  = 6'd31;
    localparam logic [5:0]       BIT_SAT   = 6'd32;

    if (CLK_DIV < 6 || POLL_PERIOD < 2 ||
        MOSI_X_LSB + MOSI_X_W != FRAME_W ||
        MISO_X_LSB + MISO_X_W != FRAME_W) begin : g_param_check
        $error("spi_master_frame: illegal CLK_DIV/POLL_PERIOD or frame layout");
    end

    spi_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [5:0]         bit_cnt_q;
    logic [FRAME_W-1:0] tx_q;
    logic [FRAME_W-1:0] rx_q;
    miso_frame_t        rx_out_q;
    logic               cs_q;
    logic               mosi_q;
    logic               busy_q;
    logic               done_q;
    logic               miso_meta_q;
    logic               miso_sync_q;

    logic               sclk_en;
    logic               sclk_w;
    logic               sclk_rise;
    logic               sclk_fall;
    logic               start_req;
    logic               accept;
    mosi_frame_t        tx_load;
    logic [FRAME_W-1:0] tx_word;

    assign tx_load = '{x: motor_xdata, y: motor_ydata, etc: mosi_etc};
    assign tx_word = tx_load;
    assign accept  = (state_q == ST_IDLE) && start_req;
    assign sclk_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

`ifdef SPI_MASTER_AUTO_POLL_EN
    localparam int POLL_W = $clog2(POLL_PERIOD);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);

    logic [POLL_W-1:0] poll_cnt_q;
    logic              poll_pend_q;
    logic              poll_tick;

    assign poll_tick = (poll_cnt_q == POLL_LAST);

    // A tick that lands while a frame is running waits for the next IDLE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt_q  <= '0;
            poll_pend_q <= 1'b0;
        end else begin
            poll_cnt_q  <= poll_tick ? '0 : poll_cnt_q + 1'b1;
            poll_pend_q <= (poll_pend_q || poll_tick) && !accept;
        end
    end

    assign start_req = start || poll_tick || poll_pend_q;
`else
    assign start_req = start;
`endif

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk   (clk),
        .reset (reset),
        .en    (sclk_en),
        .sclk  (sclk_w),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= miso;
            miso_sync_q <= miso_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_out_q  <= '0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (sclk_rise) begin
                rx_q <= {rx_q[FRAME_W-2:0], miso_sync_q};
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        state_q   <= ST_SETUP;
                        tx_q      <= tx_word;
                        mosi_q    <= tx_word[FRAME_W-1];
                        cs_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        cnt_q     <= '0;
                    end
                end
                ST_SETUP: begin
                    if (sclk_rise) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Zeros shift in behind the data, so mosi ends the frame at 0.
                    if (sclk_fall) begin
                        tx_q   <= {tx_q[FRAME_W-2:0], 1'b0};
                        mosi_q <= tx_q[FRAME_W-2];
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= BIT_SAT;
                            state_q   <= ST_HOLD;
                            cnt_q     <= '0;
                        end else if (bit_cnt_q != BIT_SAT) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q  <= ST_GAP;
                        cnt_q    <= '0;
                        cs_q     <= 1'b1;
                        mosi_q   <= 1'b0;
                        done_q   <= 1'b1;
                        rx_out_q <= rx_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sclk        = sclk_w;
    assign mosi        = mosi_q;
    assign cs          = cs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign enemy_xdata = rx_out_q.x;
    assign enemy_ydata = rx_out_q.y;
    assign miso_etc    = rx_out_q.etc;

endmodule

`default_nettype wire
